// File: rtl/seg_scan_ctrl.sv
// Four-digit 7-segment scan scheduler: blank guard, dwell, frame-aligned data latch,
// per-digit enable, leading-zero suppression and field blink.
//
// state | meaning
// BLANK | all segments and digit selects off (anti-ghosting guard)
// SHOW  | digit digit_idx driven for DWELL_CYCLES cycles
module seg_scan_ctrl #(
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 62
) (
  input  logic        clk_50mhz,
  input  logic        rst,
  input  logic [15:0] digits_bcd,
  input  logic [3:0]  digit_en,
  input  logic        lz_en,
  input  logic [3:0]  blink_mask,
  output logic [6:0]  seg,
  output logic [3:0]  key0,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);

  localparam int MAXC       = (DWELL_CYCLES > BLANK_CYCLES) ?
                              ((DWELL_CYCLES > 2) ? DWELL_CYCLES : 2) :
                              ((BLANK_CYCLES > 2) ? BLANK_CYCLES : 2);
  localparam int CW         = $clog2(MAXC);
  localparam int FW         = $clog2(BLINK_FRAMES + 1);
  localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx_nxt;
  logic [15:0]   shadow, shadow_nxt;
  logic [FW-1:0] fcnt, fcnt_nxt;
  logic          phase, phase_nxt;
  logic          blank_end, show_end;
  logic [3:0]    sup;
  logic [3:0]    nib;
  logic          lit;
  logic [6:0]    seg_nxt;
  logic [3:0]    key_nxt;
  logic          frame_done_nxt;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0: decode = 7'h40;
      4'd1: decode = 7'h79;
      4'd2: decode = 7'h24;
      4'd3: decode = 7'h30;
      4'd4: decode = 7'h19;
      4'd5: decode = 7'h12;
      4'd6: decode = 7'h02;
      4'd7: decode = 7'h78;
      4'd8: decode = 7'h00;
      4'd9: decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction

  assign blank_end = (BLANK_CYCLES == 0) || (cnt == CW'(BLANK_LAST));
  assign show_end  = (cnt == CW'(DWELL_CYCLES - 1));

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + CW'(1);
    idx_nxt    = digit_idx;
    shadow_nxt = shadow;
    fcnt_nxt   = fcnt;
    phase_nxt  = phase;
    case (state)
      BLANK: begin
        if (blank_end) begin
          state_nxt = SHOW;
          cnt_nxt   = '0;
        end
      end
      SHOW: begin
        if (show_end) begin
          cnt_nxt   = '0;
          idx_nxt   = digit_idx + 2'd1;
          state_nxt = (BLANK_CYCLES == 0) ? SHOW : BLANK;
          if (digit_idx == 2'd3) begin
            shadow_nxt = digits_bcd;
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
              fcnt_nxt  = '0;
              phase_nxt = ~phase;
            end else begin
              fcnt_nxt = fcnt + FW'(1);
            end
          end
        end
      end
      default: state_nxt = BLANK;
    endcase
  end

  // Outputs are computed from next-cycle state so the registered pins line up with the FSM.
  always_comb begin
    sup[3] = lz_en && (shadow_nxt[15:12] == 4'd0);
    sup[2] = sup[3] && (shadow_nxt[11:8] == 4'd0);
    sup[1] = sup[2] && (shadow_nxt[7:4] == 4'd0);
    sup[0] = 1'b0;
    nib    = shadow_nxt[idx_nxt*4 +: 4];
    lit    = (state_nxt == SHOW) && digit_en[idx_nxt] &&
             !(blink_mask[idx_nxt] && phase_nxt) && !sup[idx_nxt];
    seg_nxt        = lit ? decode(nib) : 7'h7F;
    key_nxt        = lit ? ~(4'b0001 << idx_nxt) : 4'hF;
    frame_done_nxt = (state_nxt == SHOW) && (idx_nxt == 2'd3) &&
                     (cnt_nxt == CW'(DWELL_CYCLES - 1));
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state      <= BLANK;
      cnt        <= '0;
      digit_idx  <= 2'd0;
      shadow     <= 16'h0000;
      fcnt       <= '0;
      phase      <= 1'b0;
      seg        <= 7'h7F;
      key0       <= 4'hF;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      digit_idx  <= idx_nxt;
      shadow     <= shadow_nxt;
      fcnt       <= fcnt_nxt;
      phase      <= phase_nxt;
      seg        <= seg_nxt;
      key0       <= key_nxt;
      frame_done <= frame_done_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: per-cycle check against a timeline model of the scan,
// plus directed literal expectations for each scenario.
module tb_seg_scan_ctrl;

  localparam int DW   = 4;
  localparam int BK   = 2;
  localparam int BF   = 2;
  localparam int SLOT = DW + BK;
  localparam int FRM  = 4 * SLOT;
  localparam logic [6:0] DEC [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic        clk;
  logic        rst;
  logic [15:0] digits_bcd;
  logic [3:0]  digit_en;
  logic        lz_en;
  logic [3:0]  blink_mask;
  logic [6:0]  seg;
  logic [3:0]  key0;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int total = 0;
  int bad   = 0;
  int t     = 0;
  int nfr   = 0;
  logic [15:0] msh = 16'h0000;

  seg_scan_ctrl #(.DWELL_CYCLES(DW), .BLANK_CYCLES(BK), .BLINK_FRAMES(BF)) dut (
    .clk_50mhz (clk),
    .rst       (rst),
    .digits_bcd(digits_bcd),
    .digit_en  (digit_en),
    .lz_en     (lz_en),
    .blink_mask(blink_mask),
    .seg       (seg),
    .key0      (key0),
    .digit_idx (digit_idx),
    .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d got=%h want=%h", nm, t, act, exp);
    end
  endtask

  function automatic logic [6:0] exp_glyph(input logic [3:0] n);
    return (n < 4'd10) ? DEC[n] : 7'h3F;
  endfunction

  // Timeline model: position within the frame picks digit and phase of the slot.
  always @(posedge clk) begin
    int pos, d, h;
    logic show, lit, ph;
    logic [6:0] es;
    logic [3:0] ek;
    if (rst) begin
      t = 0; nfr = 0; msh = 16'h0000;
    end else begin
      if (t % FRM == FRM - 1) begin
        msh = digits_bcd;
        nfr++;
      end
      t++;
    end
    #1;
    pos  = t % FRM;
    d    = pos / SLOT;
    show = (pos % SLOT) >= BK;
    ph   = ((nfr / BF) % 2) == 1;
    h    = 0;
    for (int i = 3; i >= 0; i--)
      if (h == 0 && msh[i*4 +: 4] != 4'd0) h = i;
    lit = show && digit_en[d] && !(blink_mask[d] && ph) && !(lz_en && d > h);
    es  = lit ? exp_glyph(msh[d*4 +: 4]) : 7'h7F;
    ek  = lit ? ~(4'b0001 << d) : 4'hF;
    chk("model_seg", {9'd0, seg}, {9'd0, es});
    chk("model_key0", {12'd0, key0}, {12'd0, ek});
    chk("model_idx", {14'd0, digit_idx}, 16'(d));
    chk("model_frame_done", {15'd0, frame_done}, {15'd0, pos == FRM - 1});
  end

  task automatic wait_t(input int k);
    int n = 0;
    while (t != k && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (t != k) begin
      total++;
      bad++;
      $display("FAIL wait_t got=%0d want=%0d", t, k);
    end
  endtask

  task automatic lit_at(input int k, input logic [3:0] ek, input logic [6:0] es);
    wait_t(k);
    chk("lit_key0", {12'd0, key0}, {12'd0, ek});
    chk("lit_seg", {9'd0, seg}, {9'd0, es});
  endtask

  task automatic fd_at(input int k, input logic e);
    wait_t(k);
    chk("lit_frame_done", {15'd0, frame_done}, {15'd0, e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0d", t);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; digits_bcd = 16'h1234; digit_en = 4'hF; lz_en = 1'b0; blink_mask = 4'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    lit_at(0, 4'hF, 7'h7F);
    chk("lit_idx_reset", {14'd0, digit_idx}, 16'd0);
    lit_at(1, 4'hF, 7'h7F);
    lit_at(2, 4'hE, 7'h40);
    lit_at(5, 4'hE, 7'h40);
    fd_at(22, 1'b0);
    fd_at(23, 1'b1);
    fd_at(24, 1'b0);
    lit_at(26, 4'hE, 7'h19);
    wait_t(29); digits_bcd = 16'h5678;
    lit_at(32, 4'hD, 7'h30);
    lit_at(38, 4'hB, 7'h24);
    lit_at(44, 4'h7, 7'h79);
    lit_at(50, 4'hE, 7'h00);
    lit_at(56, 4'hD, 7'h78);
    lit_at(62, 4'hB, 7'h02);
    lit_at(68, 4'h7, 7'h12);
    wait_t(70); digits_bcd = 16'h0045; lz_en = 1'b1;
    lit_at(74, 4'hE, 7'h12);
    lit_at(80, 4'hD, 7'h19);
    lit_at(86, 4'hF, 7'h7F);
    lit_at(92, 4'hF, 7'h7F);
    wait_t(94); digits_bcd = 16'h0405;
    lit_at(98, 4'hE, 7'h12);
    lit_at(104, 4'hD, 7'h40);
    lit_at(110, 4'hB, 7'h19);
    lit_at(116, 4'hF, 7'h7F);
    wait_t(118); digits_bcd = 16'h0000;
    lit_at(122, 4'hE, 7'h40);
    lit_at(128, 4'hF, 7'h7F);
    lit_at(134, 4'hF, 7'h7F);
    lit_at(140, 4'hF, 7'h7F);
    wait_t(142); digits_bcd = 16'h1234; lz_en = 1'b0; blink_mask = 4'b0001;
    lit_at(146, 4'hF, 7'h7F);
    lit_at(152, 4'hD, 7'h30);
    lit_at(170, 4'hF, 7'h7F);
    lit_at(176, 4'hD, 7'h30);
    lit_at(194, 4'hE, 7'h19);
    lit_at(218, 4'hE, 7'h19);
    lit_at(242, 4'hF, 7'h7F);
    wait_t(260); blink_mask = 4'h0; digits_bcd = 16'h12A4; digit_en = 4'b1011;
    lit_at(266, 4'hE, 7'h19);
    lit_at(272, 4'hD, 7'h3F);
    lit_at(278, 4'hF, 7'h7F);
    lit_at(284, 4'h7, 7'h79);
    wait_t(302);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lit_at(0, 4'hF, 7'h7F);
    chk("lit_idx_rerst", {14'd0, digit_idx}, 16'd0);
    chk("lit_fd_rerst", {15'd0, frame_done}, 16'd0);
    lit_at(2, 4'hE, 7'h40);
    fd_at(23, 1'b1);
    lit_at(26, 4'hE, 7'h19);
    wait_t(30);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
